// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dmem_responder_pkg                                 |
// | Description : Shared state encoding, defaults and helpers for    |
// |               the data-memory responder.                         |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package dmem_responder_pkg;

  localparam int unsigned DEFAULT_DEPTH_LOG2  = 10;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  // Wait counter width covers the legal 0..15 wait-state range.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // A word access is misaligned whenever either byte-offset bit is set.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dmem_array                                         |
// | Description : 2^DEPTH_LOG2 x 32 storage, one synchronous write   |
// |               port and one synchronous read port, no reset.      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
import dmem_responder_pkg::*;

module dmem_array #(
  parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  // Write and read ports; the read register holds until the next read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dmem_responder                                     |
// | Description : Multi-cycle data-memory responder for the MEM      |
// |               stage with programmable wait states, pipeline      |
// |               stall and misaligned-access error pulse.           |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
import dmem_responder_pkg::*;

module dmem_responder #(
  parameter int unsigned DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_MEM_mem_DmemAddr,
  input  logic [31:0] i_MEM_mem_DmemDataW,
  input  logic        i_MEM_mem_MemRead,
  input  logic        i_MEM_mem_MemWrite,
  output logic [31:0] o_MEM_mem_DmemDataR,
  output logic        o_MEM_mem_Stall,
  output logic        o_MEM_mem_AddrErr
);

  localparam logic [CNT_W-1:0] c_WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             rd_q;
  logic             wr_q;
  logic             rsel_q;
  logic             err_q;

  logic             w_req;
  logic             w_in_idle;
  logic [31:0]      w_acc_addr;
  logic [31:0]      w_acc_wdata;
  logic             w_acc_rd;
  logic             w_acc_wr;
  logic             w_misal;
  logic             w_enter_resp;
  logic             w_arr_we;
  logic             w_arr_re;
  logic [31:0]      w_arr_rdata;
  logic             w_unused_addr_bits;

  assign w_req     = i_MEM_mem_MemRead | i_MEM_mem_MemWrite;
  assign w_in_idle = (state_q == ST_IDLE);

  // With zero wait states the access completes on the same edge that
  // would latch it, so the live inputs are used while still in IDLE.
  assign w_acc_addr  = w_in_idle ? i_MEM_mem_DmemAddr  : addr_q;
  assign w_acc_wdata = w_in_idle ? i_MEM_mem_DmemDataW : wdata_q;
  assign w_acc_rd    = w_in_idle ? i_MEM_mem_MemRead   : rd_q;
  assign w_acc_wr    = w_in_idle ? i_MEM_mem_MemWrite  : wr_q;
  assign w_misal     = is_misaligned(w_acc_addr[1:0]);

  // Gated by rst so a reset coinciding with this edge aborts the commit.
  assign w_enter_resp = !rst &&
    ((w_in_idle && w_req && (WAIT_CYCLES == 0)) ||
     ((state_q == ST_WAIT) && (cnt_q == '0)));

  // Simultaneous read+write is treated as a write only.
  assign w_arr_we = w_enter_resp && w_acc_wr && !w_misal;
  assign w_arr_re = w_enter_resp && w_acc_rd && !w_acc_wr && !w_misal;

  // Upper address bits alias; they intentionally select nothing.
  assign w_unused_addr_bits = ^w_acc_addr[31:DEPTH_LOG2+2];

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .we_i    (w_arr_we),
    .waddr_i (w_acc_addr[DEPTH_LOG2+1:2]),
    .wdata_i (w_acc_wdata),
    .re_i    (w_arr_re),
    .raddr_i (w_acc_addr[DEPTH_LOG2+1:2]),
    .rdata_o (w_arr_rdata)
  );

  // Access sequencer: state, wait counter, request latches, output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rsel_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= w_enter_resp && w_misal;
      if (w_enter_resp) begin
        if (w_misal) begin
          rsel_q <= 1'b0;
        end else if (w_arr_re) begin
          rsel_q <= 1'b1;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (w_req) begin
            addr_q  <= i_MEM_mem_DmemAddr;
            wdata_q <= i_MEM_mem_DmemDataW;
            rd_q    <= i_MEM_mem_MemRead;
            wr_q    <= i_MEM_mem_MemWrite;
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= c_WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - c_CNT_ONE;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Read data is the array read register after a good read, else zero.
  assign o_MEM_mem_DmemDataR = rsel_q ? w_arr_rdata : 32'd0;
  assign o_MEM_mem_Stall     = !rst && ((w_in_idle && w_req) || (state_q == ST_WAIT));
  assign o_MEM_mem_AddrErr   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_dmem_responder                                  |
// | Description : Directed self-checking bench for dmem_responder    |
// |               with WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] datar_s [2];
  logic        rd_s    [2];
  logic        wr_s    [2];
  logic        stall_s [2];
  logic        err_s   [2];

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_m   [2][1024];
  logic [31:0] datar_m [2];
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk                 (clk),
    .rst                 (rst),
    .i_MEM_mem_DmemAddr  (addr_s[0]),
    .i_MEM_mem_DmemDataW (wdata_s[0]),
    .i_MEM_mem_MemRead   (rd_s[0]),
    .i_MEM_mem_MemWrite  (wr_s[0]),
    .o_MEM_mem_DmemDataR (datar_s[0]),
    .o_MEM_mem_Stall     (stall_s[0]),
    .o_MEM_mem_AddrErr   (err_s[0])
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk                 (clk),
    .rst                 (rst),
    .i_MEM_mem_DmemAddr  (addr_s[1]),
    .i_MEM_mem_DmemDataW (wdata_s[1]),
    .i_MEM_mem_MemRead   (rd_s[1]),
    .i_MEM_mem_MemWrite  (wr_s[1]),
    .o_MEM_mem_DmemDataR (datar_s[1]),
    .o_MEM_mem_Stall     (stall_s[1]),
    .o_MEM_mem_AddrErr   (err_s[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Idle cycles: no request; stall and error low, read data held.
  task automatic idle(input int n);
    for (int k = 0; k < 2; k++) begin
      rd_s[k] = 1'b0;
      wr_s[k] = 1'b0;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("idle_stall_d%0d", k), stall_s[k], 1'b0);
        check($sformatf("idle_err_d%0d", k), err_s[k], 1'b0);
        check($sformatf("idle_datar_d%0d", k), datar_s[k], datar_m[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  // One access held by the pipeline until Stall drops; the response is
  // predicted when driven and compared when the RESP cycle arrives.
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit scramble);
    exp_t e;
    int   wc;
    wc = (sel == 0) ? 2 : 0;
    if (a[1:0] != 2'b00) begin
      datar_m[sel] = 32'd0;
      e.err = 1'b1;
    end else begin
      e.err = 1'b0;
      if (wr) mem_m[sel][a[11:2]] = wd;
      else if (rd) datar_m[sel] = mem_m[sel][a[11:2]];
    end
    e.data = datar_m[sel];
    sb_q.push_back(e);
    addr_s[sel]  = a;
    wdata_s[sel] = wd;
    rd_s[sel]    = rd;
    wr_s[sel]    = wr;
    for (int i = 0; i <= wc; i++) begin
      @(negedge clk);
      check($sformatf("stall_c%0d_a%h", i, a), stall_s[sel], 1'b1);
      check($sformatf("err_wait_c%0d_a%h", i, a), err_s[sel], 1'b0);
      @(posedge clk); #1;
      if (scramble && i < wc) begin
        addr_s[sel]  = $urandom;
        wdata_s[sel] = $urandom;
      end
    end
    addr_s[sel]  = a;
    wdata_s[sel] = wd;
    @(negedge clk);
    e = sb_q.pop_front();
    check($sformatf("resp_stall_a%h", a), stall_s[sel], 1'b0);
    check($sformatf("resp_datar_a%h", a), datar_s[sel], e.data);
    check($sformatf("resp_err_a%h", a), err_s[sel], e.err);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      addr_s[k] = '0; wdata_s[k] = '0; rd_s[k] = 1'b0; wr_s[k] = 1'b0;
      datar_m[k] = 32'd0;
    end
    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_stall_d%0d", k), stall_s[k], 1'b0);
      check($sformatf("rst_datar_d%0d", k), datar_s[k], 32'd0);
      check($sformatf("rst_err_d%0d", k), err_s[k], 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Basic write then read with two wait states.
    access(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    idle(1);

    // Alias wrap: 0x1004 and 0x4 map to the same word.
    access(0, 1'b0, 1'b1, 32'h0000_1004, 32'h1234_5678, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);

    // Misaligned write must not disturb the word and zeroes DataR.
    access(0, 1'b0, 1'b1, 32'h0000_0020, 32'h55AA_55AA, 1'b0);
    access(0, 1'b0, 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 1'b0);
    idle(1);
    access(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 1'b0);
    idle(1);

    // Reset during WAIT of a write aborts it.
    access(0, 1'b0, 1'b1, 32'h0000_0008, 32'h1111_2222, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
    addr_s[0] = 32'h8; wdata_s[0] = 32'hA5A5_A5A5; wr_s[0] = 1'b1; rd_s[0] = 1'b0;
    @(negedge clk);
    check("abort1_stall_idle", stall_s[0], 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    datar_m[0] = 32'd0;
    datar_m[1] = 32'd0;
    #1;
    check("abort1_stall", stall_s[0], 1'b0);
    check("abort1_datar", datar_s[0], 32'd0);
    check("abort1_err", err_s[0], 1'b0);
    @(posedge clk); #1;
    wr_s[0] = 1'b0;
    rst = 1'b0;
    idle(1);

    // Reset coinciding with the edge that would enter RESP.
    access(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
    addr_s[0] = 32'h8; wdata_s[0] = 32'hBBBB_CCCC; wr_s[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort2_stall_wait", stall_s[0], 1'b1);
    rst = 1'b1;
    datar_m[0] = 32'd0;
    datar_m[1] = 32'd0;
    @(posedge clk); #1;
    check("abort2_stall", stall_s[0], 1'b0);
    check("abort2_datar", datar_s[0], 32'd0);
    check("abort2_err", err_s[0], 1'b0);
    wr_s[0] = 1'b0;
    rst = 1'b0;
    idle(1);
    access(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0);

    // Read+write together acts as a write; DataR keeps the prior read.
    access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    access(0, 1'b1, 1'b1, 32'h0000_000C, 32'h0000_0001, 1'b0);
    idle(1);
    access(0, 1'b1, 1'b0, 32'h0000_000C, 32'h0, 1'b0);

    // Inputs wiggled during WAIT must not affect the latched access.
    access(0, 1'b0, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 1'b1);
    access(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b1);
    idle(1);

    // Zero wait states: back-to-back accesses held by the pipeline.
    access(1, 1'b0, 1'b1, 32'h0000_0000, 32'hAAAA_0000, 1'b0);
    access(1, 1'b0, 1'b1, 32'h0000_0004, 32'hBBBB_1111, 1'b0);
    access(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
    access(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
    access(1, 1'b0, 1'b1, 32'h0000_0101, 32'h1, 1'b0);
    idle(2);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL expose parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words stored.
REQ-002 SHALL expose parameter WAIT_CYCLES, default 2, meaning wait states inserted per access; legal range 0..15.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk input 1 is the clock, rising edge; rst input 1 is the reset.
REQ-004 i_MEM_mem_DmemAddr  input  32  byte address from the MEM stage.
REQ-005 i_MEM_mem_DmemDataW  input  32  write data.
REQ-006 i_MEM_mem_MemRead  input  1  read request.
REQ-007 i_MEM_mem_MemWrite  input  1  write request.
REQ-008 o_MEM_mem_DmemDataR  output  32  read data, registered.
REQ-009 o_MEM_mem_Stall  output  1  pipeline hold request.
REQ-010 o_MEM_mem_AddrErr  output  1  misaligned-access pulse, registered.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-012 IDLE with (MemRead|MemWrite)=1 SHALL latch addr, wdata and op at the clock edge.
REQ-013 From IDLE, the next state SHALL be RESP when WAIT_CYCLES=0; otherwise it SHALL be WAIT, with counter=WAIT_CYCLES-1.
REQ-014 In WAIT, the FSM SHALL go to RESP when counter=0; otherwise it SHALL decrement the counter.
REQ-015 RESP SHALL always return to IDLE on the next edge.
REQ-016 A request present during RESP SHALL be ignored, because it is the completing access.
REQ-017 Stall SHALL be combinational: 1 in IDLE while a request is present, 1 throughout WAIT, 0 in RESP, 0 otherwise.
REQ-018 Latency: a request first seen in IDLE in cycle 0 SHALL hold Stall high in cycles 0..WAIT_CYCLES and present DataR valid in cycle WAIT_CYCLES+1 (RESP).
REQ-019 Input changes during WAIT SHALL be ignored; only the latched values are used.
REQ-020 Word index SHALL be addr[DEPTH_LOG2+1:2]; upper address bits are ignored, so addresses alias modulo 4*2^DEPTH_LOG2 bytes.
REQ-021 An aligned write SHALL commit to the array on the edge entering RESP.
REQ-022 An aligned read SHALL load DataR from the array on the edge entering RESP.
REQ-023 DataR SHALL hold its value until the next completed read.
REQ-024 When MemRead and MemWrite are both 1, the access SHALL be performed as a write only, with DataR unchanged.
REQ-025 A misaligned access (addr[1:0]!=0) SHALL follow the same state and timing sequence as an aligned access.
REQ-026 A misaligned access SHALL NOT write the array and SHALL load DataR with 0.
REQ-027 A misaligned access SHALL assert AddrErr for exactly the RESP cycle.
REQ-028 AddrErr SHALL be 0 in all other cycles.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, counter=0, DataR=0, AddrErr=0 and Stall=0, regardless of inputs.
REQ-030 Reset asserted mid-access SHALL abort the access; no write SHALL commit, including when reset coincides with the edge entering RESP.
REQ-031 Array contents SHALL NOT be reset.
REQ-032 After rst deasserts, the first edge with a request present SHALL start a new access from IDLE.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the default values of DEPTH_LOG2 and WAIT_CYCLES.
REQ-034 Storage SHALL be one sub-module, dmem_array: 2^DEPTH_LOG2 x 32 words, one synchronous write port, one synchronous read port, no reset.
REQ-035 The FSM, counter, request latches and output registers SHALL reside in dmem_responder.

Verification
REQ-036 WAIT_CYCLES=2, write 0x0000_0010 <- 0xDEAD_BEEF: Stall SHALL be high for 3 cycles; then a read of 0x10 SHALL give DataR=0xDEAD_BEEF in cycle 3 with Stall=0.
REQ-037 WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 held by the pipeline: each read SHALL show Stall high for 1 cycle and DataR valid in the next cycle, with no lost or duplicated access.
REQ-038 DEPTH_LOG2=10, write 0x0000_1004 <- 0x1234_5678, then read 0x0000_0004: DataR SHALL equal 0x1234_5678 (alias wrap).
REQ-039 Misaligned write 0x0000_0022 <- 0xFFFF_FFFF: AddrErr SHALL be 1 for one cycle in RESP, a read of 0x20 SHALL return its prior value, and DataR SHALL equal 0 after the errored access.
REQ-040 rst asserted during WAIT of a write to 0x8 <- 0xA5A5_A5A5: Stall and DataR SHALL go to 0 at once, and a later read of 0x8 SHALL return the old value.
REQ-041 MemRead=MemWrite=1 to 0xC with 0x0000_0001: the array SHALL be updated, DataR SHALL stay unchanged, and a following read SHALL return 0x1.
